spread_tx: RTL and testbench

Transmit-side DSSS spreader: accepts one (I, Q) data-bit pair per symbol over a valid/ready handshake and spreads each bit over SF chips of an LFSR-generated PN sequence. Emits 2-bit signed ±1 chips on the I and Q paths at a chip-enable rate, with the PN chip exported as `local_code`. The receive-side correlator, fed with the same PN sequence, recovers the data sign, where `local_code`=1 passes the chip and 0 negates it.

---
 rtl/spread_tx.sv | 69 ++++++
 tb/tb_spread_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spread_tx.sv
// spread_tx: DSSS transmit spreader, spreads each (I,Q) symbol over SF chips of a Fibonacci LFSR PN code
module spread_tx #(
    parameter int LFSR_LEN = 3,
    parameter logic [LFSR_LEN-1:0] TAPS = 3'b011,
    parameter logic [LFSR_LEN-1:0] SEED = 3'b001,
    parameter int SF = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chip_en,
    input  logic              sym_valid,
    output logic              sym_ready,
    input  logic              sym_i,
    input  logic              sym_q,
    output logic signed [1:0] I_out,
    output logic signed [1:0] Q_out,
    output logic              local_code,
    output logic              out_valid,
    output logic              sym_start
);
    localparam int CW = SF > 1 ? $clog2(SF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SF - 1);
    typedef enum logic {IDLE, SPREAD} state_t;
    state_t state, state_nx;
    logic [LFSR_LEN-1:0] lfsr;
    logic [CW-1:0] cnt;
    logic bi, bq, chip, last, accept;
    assign chip = state == SPREAD && chip_en;
    assign last = chip && cnt == LAST;
    assign sym_ready = state == IDLE || last;
    assign accept = sym_valid && sym_ready;
    always_comb begin
        state_nx = state;
        state_nx = accept ? SPREAD : last ? IDLE : state;
    end
    // counter wraps to zero on the last chip, so a same-edge accept starts cleanly at chip 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            cnt        <= '0;
            bi         <= 1'b0;
            bq         <= 1'b0;
            I_out      <= '0;
            Q_out      <= '0;
            local_code <= 1'b0;
            out_valid  <= 1'b0;
            sym_start  <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= chip;
            sym_start <= chip && cnt == '0;
            if (chip) begin
                I_out      <= bi == lfsr[0] ? 2'sb01 : 2'sb11;
                Q_out      <= bq == lfsr[0] ? 2'sb01 : 2'sb11;
                local_code <= lfsr[0];
                lfsr       <= {^(lfsr & TAPS), lfsr[LFSR_LEN-1:1]};
                cnt        <= last ? '0 : cnt + 1'b1;
            end else if (chip_en) begin
                I_out <= '0;
                Q_out <= '0;
            end
            if (accept) begin
                bi <= sym_i;
                bq <= sym_q;
            end
        end
    end
endmodule

// File: tb/tb_spread_tx.sv
// tb_spread_tx: table vectors, hand sequences and a chip-level scoreboard with correlator check for spread_tx
module tb_spread_tx;
    logic clk = 1'b0, rst = 1'b1, chip_en = 1'b1, sym_valid = 1'b0, sym_i = 1'b0, sym_q = 1'b0;
    logic signed [1:0] I_out, Q_out;
    logic sym_ready, local_code, out_valid, sym_start;
    int errors = 0, checks = 0, en_mode = 0, pidx = 0;
    logic pn [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    typedef struct { logic i, q, f; } ent_t;
    ent_t mq[$];
    typedef struct { logic i, q; logic [0:6] ip, qp; } vec_t;
    vec_t tbl [4];

    spread_tx dut (.clk(clk), .rst(rst), .chip_en(chip_en), .sym_valid(sym_valid), .sym_ready(sym_ready),
                   .sym_i(sym_i), .sym_q(sym_q), .I_out(I_out), .Q_out(Q_out), .local_code(local_code),
                   .out_valid(out_valid), .sym_start(sym_start));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            chip_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? (ph % 3 == 0) : 1'($urandom_range(0, 1));
        end
    end

    always @(posedge rst) begin
        mq.delete();
        pidx = 0;
    end

    // scoreboard: every emitted chip is data sign times PN chip, PN index runs over all data chips since reset
    always @(negedge clk) if (!rst) begin
        if (out_valid) begin
            if (mq.size() == 0) chk("spurious_chip", 1, 0);
            else begin
                ent_t e;
                logic c;
                e = mq.pop_front();
                c = pn[pidx];
                pidx = (pidx + 1) % 7;
                chk("mon_i", I_out, e.i == c ? 1 : -1);
                chk("mon_q", Q_out, e.q == c ? 1 : -1);
                chk("mon_code", local_code, c);
                chk("mon_start", sym_start, e.f);
                chk("despread_i", local_code ? int'(I_out) : -int'(I_out), e.i ? 1 : -1);
                chk("despread_q", local_code ? int'(Q_out) : -int'(Q_out), e.q ? 1 : -1);
            end
        end else chk("mon_start_idle", sym_start, 0);
        chk("mon_ready", sym_ready, mq.size() == 0 || (mq.size() == 1 && chip_en));
        if (sym_valid && sym_ready)
            for (int k = 0; k < 7; k++) mq.push_back('{sym_i, sym_q, k == 0});
    end

    task automatic zeros(input string nm);
        chk({nm, "_i"}, I_out, 0);
        chk({nm, "_q"}, Q_out, 0);
        chk({nm, "_code"}, local_code, 0);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_start"}, sym_start, 0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 zeros("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", sym_ready, 1);
    endtask

    task automatic send_sym(input logic i, input logic q);
        int n = 0;
        @(posedge clk);
        #1;
        sym_valid = 1'b1;
        sym_i = i;
        sym_q = q;
        @(negedge clk);
        while (!sym_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        sym_i = 1'($urandom);
        sym_q = 1'($urandom);
    endtask

    task automatic check_sym(input logic [0:6] ip, input logic [0:6] qp);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            chk("sym_valid_out", out_valid, 1);
            chk("sym_i_chip", I_out, ip[c] ? 1 : -1);
            chk("sym_q_chip", Q_out, qp[c] ? 1 : -1);
            chk("sym_code", local_code, pn[c]);
            chk("sym_start_flag", sym_start, c == 0);
        end
        @(negedge clk);
        chk("sym_after_valid", out_valid, 0);
        chk("sym_after_i", I_out, 0);
        chk("sym_after_q", Q_out, 0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 7'b1001011, 7'b0110100};
        tbl[1] = '{1'b0, 1'b1, 7'b0110100, 7'b1001011};
        tbl[2] = '{1'b1, 1'b1, 7'b1001011, 7'b1001011};
        tbl[3] = '{1'b0, 1'b0, 7'b0110100, 7'b0110100};
        #3 zeros("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", sym_ready, 1);
        foreach (tbl[t]) begin
            pulse_rst();
            send_sym(tbl[t].i, tbl[t].q);
            check_sym(tbl[t].ip, tbl[t].qp);
        end
        begin
            int run = 0, rdy = 0;
            pulse_rst();
            @(posedge clk);
            #1 sym_valid = 1'b1; sym_i = 1'b1; sym_q = 1'b0;
            @(posedge clk);
            #1 sym_i = 1'b0; sym_q = 1'b1;
            @(negedge clk);
            for (int n = 0; n < 15; n++) begin
                @(negedge clk);
                if (n < 14) run += int'(out_valid);
                else chk("b2b_tail_idle", out_valid, 0);
                if (n < 13) rdy += int'(sym_ready);
                if (n == 5) chk("b2b_ready_last_chip", sym_ready, 1);
                if (n == 7) #1 sym_valid = 1'b0;
            end
            chk("b2b_pulses", run, 14);
            chk("b2b_ready_count", rdy, 2);
        end
        begin
            int seen = 0, gap = 0;
            logic signed [1:0] li = '0;
            pulse_rst();
            en_mode = 1;
            send_sym(1'b1, 1'b0);
            for (int n = 0; n < 60 && seen < 7; n++) begin
                @(negedge clk);
                gap++;
                if (out_valid) begin
                    if (seen > 0) chk("stall_gap", gap, 3);
                    seen++;
                    gap = 0;
                    li = I_out;
                end else if (seen > 0) chk("stall_hold", I_out, li);
            end
            chk("stall_chips", seen, 7);
            en_mode = 0;
        end
        pulse_rst();
        send_sym(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        pulse_rst();
        send_sym(1'b1, 1'b1);
        check_sym(7'b1001011, 7'b1001011);
        begin
            int n = 0;
            en_mode = 2;
            for (int s = 0; s < 20; s++) begin
                send_sym(1'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            while (mq.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("loopback_drain", mq.size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
